// File: rtl/dk_voice_pkg.sv
// Shared types and arithmetic helpers for the dk_voice_bank square-wave voice mixer.
package dk_voice_pkg;

  localparam int          ENV_W   = 15;
  localparam logic [14:0] ENV_MAX = 15'h7FFF;
  // Wide enough for eight full-scale voices, so the sum is exact before saturation.
  localparam int          ACC_W   = 19;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_RISE = 2'd1,
    V_HOLD = 2'd2,
    V_FALL = 2'd3
  } voice_state_e;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_VOICE = 2'd1,
    S_EMIT  = 2'd2
  } seq_state_e;

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > 19'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -19'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // The step magnitude is truncated toward zero and forced to at least 1,
  // so env lands on target exactly and never overshoots.
  function automatic logic [14:0] env_step(input logic [14:0] target,
                                           input logic [14:0] env,
                                           input int unsigned shift);
    logic [14:0] mag;
    if (target > env) begin
      mag = (target - env) >> shift;
      if (mag == 15'd0) begin
        mag = 15'd1;
      end else begin
        mag = mag;
      end
      return env + mag;
    end else if (target < env) begin
      mag = (env - target) >> shift;
      if (mag == 15'd0) begin
        mag = 15'd1;
      end else begin
        mag = mag;
      end
      return env - mag;
    end else begin
      return env;
    end
  endfunction

endpackage

// File: rtl/dk_voice_env.sv
// One voice: envelope, phase accumulator, one-shot hold counter and trigger edge detect.
module dk_voice_env
  import dk_voice_pkg::*;
#(
  parameter int ATTACK_SHIFT = 2,
  parameter int DECAY_SHIFT  = 4,
  parameter int ONE_SHOT     = 0,
  parameter int HOLD_SAMPLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               trig_i,
  input  logic [15:0]        freq_inc_i,
  output logic signed [15:0] contrib_o
);

  localparam int HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);

  logic [14:0]       env_q, env_d, target_s;
  logic [15:0]       phase_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hist_q, edge_s;
  voice_state_e      state_q, state_d;

  // Next envelope, hold count and state label for this tick.
  always_comb begin
    edge_s   = trig_i & ~hist_q;
    hold_d   = hold_q;
    target_s = 15'd0;
    env_d    = env_q;
    state_d  = state_q;
    if (ONE_SHOT != 0) begin
      if (edge_s) begin
        hold_d = HOLD_LOAD;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else begin
        hold_d = '0;
      end
      target_s = (hold_d != '0) ? ENV_MAX : 15'd0;
    end else begin
      target_s = trig_i ? ENV_MAX : 15'd0;
    end
    if (state_q == V_IDLE && target_s == 15'd0) begin
      env_d = env_q;
    end else if (target_s > env_q) begin
      env_d = env_step(target_s, env_q, ATTACK_SHIFT);
    end else begin
      env_d = env_step(target_s, env_q, DECAY_SHIFT);
    end
    if (env_d == target_s) begin
      state_d = (target_s == 15'd0) ? V_IDLE : V_HOLD;
    end else if (target_s > env_d) begin
      state_d = V_RISE;
    end else begin
      state_d = V_FALL;
    end
    contrib_o = phase_q[15] ? -$signed({1'b0, env_d}) : $signed({1'b0, env_d});
  end

  // Voice state advances only on its sequencer slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      env_q   <= 15'd0;
      phase_q <= 16'd0;
      hold_q  <= '0;
      hist_q  <= 1'b0;
      state_q <= V_IDLE;
    end else if (en_i) begin
      env_q   <= env_d;
      phase_q <= phase_q + freq_inc_i;
      hold_q  <= hold_d;
      hist_q  <= trig_i;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/dk_voice_bank.sv
// Time-multiplexed bank of enveloped square-wave voices mixed into one saturated sample per tick.
module dk_voice_bank
  import dk_voice_pkg::*;
#(
  parameter int CLOCK_RATE   = 120000,
  parameter int SAMPLE_RATE  = 48000,
  parameter int CHANNELS     = 2,
  parameter int ATTACK_SHIFT = 2,
  parameter int DECAY_SHIFT  = 4,
  parameter int ONE_SHOT     = 0,
  parameter int HOLD_SAMPLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     audio_clk_en,
  input  logic [CHANNELS-1:0]      trigger,
  input  logic [CHANNELS*16-1:0]   freq_inc,
  output logic signed [15:0]       out,
  output logic                     out_valid,
  output logic                     busy
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("dk_voice_bank: CHANNELS must be 1..8");
  end
  if (CLOCK_RATE / SAMPLE_RATE < CHANNELS + 2) begin : g_bad_rate
    $error("dk_voice_bank: too few clocks per sample for CHANNELS voices");
  end

  seq_state_e                state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CHANNELS-1:0]       trig_q;
  logic [CHANNELS*16-1:0]    freq_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [15:0]        out_q;
  logic                      out_valid_q, busy_q;
  logic [CHANNELS-1:0]       upd_s;
  logic signed [15:0]        contrib_s [CHANNELS];
  logic signed [15:0]        sel_s;
  logic signed [ACC_W-1:0]   sel_ext_s;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_voice
    assign upd_s[k] = (state_q == S_VOICE) && (idx_q == IDX_W'(k));
    dk_voice_env #(
      .ATTACK_SHIFT(ATTACK_SHIFT),
      .DECAY_SHIFT (DECAY_SHIFT),
      .ONE_SHOT    (ONE_SHOT),
      .HOLD_SAMPLES(HOLD_SAMPLES)
    ) u_voice (
      .clk       (clk),
      .reset     (reset),
      .en_i      (upd_s[k]),
      .trig_i    (trig_q[k]),
      .freq_inc_i(freq_q[16*k +: 16]),
      .contrib_o (contrib_s[k])
    );
  end

  // Select the contribution of the voice being updated this cycle.
  always_comb begin
    sel_s = 16'sd0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_s = contrib_s[k];
      end else begin
        sel_s = sel_s;
      end
    end
    sel_ext_s = {{(ACC_W-16){sel_s[15]}}, sel_s};
  end

  // Sequencer: capture on tick, walk the voices, then emit the saturated mix.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT;
      idx_q       <= '0;
      trig_q      <= '0;
      freq_q      <= '0;
      acc_q       <= '0;
      out_q       <= 16'sd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          out_valid_q <= 1'b0;
          if (audio_clk_en) begin
            trig_q  <= trigger;
            freq_q  <= freq_inc;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_VOICE;
          end
        end
        S_VOICE: begin
          acc_q <= (idx_q == '0) ? sel_ext_s : acc_q + sel_ext_s;
          if (idx_q == IDX_W'(CHANNELS - 1)) begin
            state_q <= S_EMIT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_EMIT: begin
          out_q       <= sat16(acc_q);
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_WAIT;
        end
        default: begin
          state_q <= S_WAIT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dk_voice_bank.sv
// Scoreboard bench: a gate-mode 2-voice bank and a one-shot 4-voice bank share one clock.
module tb_dk_voice_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_a, en_a, reset_b, en_b;
  logic [1:0]         trig_a;
  logic [31:0]        freq_a;
  logic [3:0]         trig_b;
  logic [63:0]        freq_b;
  logic signed [15:0] out_a, out_b;
  logic               out_valid_a, busy_a, out_valid_b, busy_b;

  dk_voice_bank #(.CLOCK_RATE(120000), .SAMPLE_RATE(20000), .CHANNELS(2),
                  .ATTACK_SHIFT(2), .DECAY_SHIFT(4), .ONE_SHOT(0), .HOLD_SAMPLES(64)) dut_a (
    .clk(clk), .reset(reset_a), .audio_clk_en(en_a), .trigger(trig_a), .freq_inc(freq_a),
    .out(out_a), .out_valid(out_valid_a), .busy(busy_a));

  dk_voice_bank #(.CLOCK_RATE(120000), .SAMPLE_RATE(12000), .CHANNELS(4),
                  .ATTACK_SHIFT(2), .DECAY_SHIFT(4), .ONE_SHOT(1), .HOLD_SAMPLES(4)) dut_b (
    .clk(clk), .reset(reset_b), .audio_clk_en(en_b), .trigger(trig_b), .freq_inc(freq_b),
    .out(out_b), .out_valid(out_valid_b), .busy(busy_b));

  int n_pass = 0;
  int n_total = 0;
  int q_a[$];
  int q_b[$];
  int env_m[2];
  int phase_m[2];
  int exp_a_m, exp_b_m;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference envelope step: signed difference divided (truncating) by 2^shift.
  function automatic int step_m(input int tgt, input int env);
    int sh, d;
    sh = (tgt > env) ? 2 : 4;
    d = (tgt - env) / (1 << sh);
    if (d == 0 && tgt != env) d = (tgt > env) ? 1 : -1;
    return env + d;
  endfunction

  task automatic tick_a(input logic [1:0] trg, input int f0, input int f1,
                        input bit directed, input int hand);
    int sum, f[2];
    f[0] = f0; f[1] = f1; sum = 0;
    for (int k = 0; k < 2; k++) begin
      env_m[k] = step_m(trg[k] ? 32767 : 0, env_m[k]);
      sum += (phase_m[k] >= 32768) ? -env_m[k] : env_m[k];
      phase_m[k] = (phase_m[k] + f[k]) % 65536;
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    q_a.push_back(directed ? hand : sum);
    @(negedge clk);
    trig_a = trg; freq_a[15:0] = f0[15:0]; freq_a[31:16] = f1[15:0]; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Issues one tick on bank B, checking busy and the out_valid latency; optionally
  // fires a stray tick inside the busy window.
  task automatic tick_b(input logic [3:0] trg, input int hand, input bit stray);
    int lat;
    lat = 0;
    q_b.push_back(hand);
    @(negedge clk);
    trig_b = trg; en_b = 1'b1;
    @(posedge clk); #1;
    en_b = 1'b0;
    chk("b_busy_after_tick", int'(busy_b), 1);
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      en_b = (stray && c == 2);
      if (out_valid_b) lat = c;
    end
    en_b = 1'b0;
    chk("b_valid_latency", lat, 5);
    chk("b_busy_at_emit", int'(busy_b), 0);
    repeat (6) @(posedge clk);
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (out_valid_a) begin
      if (q_a.size() == 0) begin
        n_total++;
        $display("FAIL a_extra_valid: out=%0d with nothing expected", out_a);
      end else begin
        exp_a_m = q_a.pop_front();
        chk("a_out", int'(out_a), exp_a_m);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_b) begin
      if (q_b.size() == 0) begin
        n_total++;
        $display("FAIL b_extra_valid: out=%0d with nothing expected", out_b);
      end else begin
        exp_b_m = q_b.pop_front();
        chk("b_out", int'(out_b), exp_b_m);
      end
    end
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    trig_a = '0; freq_a = '0; trig_b = '0; freq_b = '0;
    for (int k = 0; k < 2; k++) begin env_m[k] = 0; phase_m[k] = 0; end
    repeat (3) @(posedge clk); #1;
    chk("a_reset_out", int'(out_a), 0);
    chk("a_reset_valid", int'(out_valid_a), 0);
    chk("a_reset_busy", int'(busy_a), 0);
    chk("b_reset_out", int'(out_b), 0);
    chk("b_reset_busy", int'(busy_b), 0);
    @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;
    repeat (2) @(negedge clk);

    // Gate rise on voice 0 with a half-rate square wave.
    tick_a(2'b01, 32768, 0, 1'b1, 8191);
    tick_a(2'b01, 32768, 0, 1'b1, -14335);
    for (int i = 0; i < 42; i++) tick_a(2'b01, 32768, 0, 1'b0, 0);
    tick_a(2'b01, 32768, 0, 1'b1, 32767);
    tick_a(2'b01, 32768, 0, 1'b1, -32767);
    // Release: exponential decay to exactly zero.
    tick_a(2'b00, 32768, 0, 1'b1, 30720);
    tick_a(2'b00, 32768, 0, 1'b1, -28800);
    for (int i = 0; i < 150; i++) tick_a(2'b00, 32768, 0, 1'b0, 0);
    tick_a(2'b00, 32768, 0, 1'b1, 0);
    tick_a(2'b00, 32768, 0, 1'b1, 0);
    // Saturation with both voices at full level.
    for (int i = 0; i < 43; i++) tick_a(2'b11, 0, 0, 1'b0, 0);
    tick_a(2'b11, 0, 0, 1'b1, 32767);
    tick_a(2'b11, 32768, 32768, 1'b1, 32767);
    tick_a(2'b11, 0, 0, 1'b1, -32768);

    // One-shot: hold for four ticks, decay, then retrigger during the fall.
    tick_b(4'b0001, 8191, 1'b0);
    tick_b(4'b0000, 14335, 1'b0);
    tick_b(4'b0000, 18943, 1'b1);
    tick_b(4'b0000, 22399, 1'b0);
    tick_b(4'b0000, 21000, 1'b0);
    tick_b(4'b0000, 19688, 1'b0);
    tick_b(4'b0001, 22957, 1'b0);
    tick_b(4'b0001, 25409, 1'b0);
    chk("b_out_held", int'(out_b), 25409);

    // Reset while voice 1 is being processed discards the tick.
    @(negedge clk);
    trig_b = 4'b0001; en_b = 1'b1;
    @(posedge clk); #1;
    en_b = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
    chk("b_rst_out", int'(out_b), 0);
    chk("b_rst_busy", int'(busy_b), 0);
    chk("b_rst_valid", int'(out_valid_b), 0);
    reset_b = 1'b0;
    repeat (10) @(posedge clk);
    tick_b(4'b0001, 8191, 1'b0);

    repeat (20) @(posedge clk);
    chk("a_pending", q_a.size(), 0);
    chk("b_pending", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
